// File: rtl/fir_poly.sv
// Polyphase decimating FIR: one output per strobe frame. Samples are staged every clock,
// distributed to M bank delay lines on each strobe, then all banks are multiplied by their
// tap column in parallel over BANK_LEN clocks and reduced into a pending result. That result
// is normalised, saturated and presented on the next strobe.
module fir_poly #(
  parameter int N_TAPS         = 120,
  parameter int M              = 20,
  parameter int M_LOG2         = 5,
  parameter int BANK_LEN       = 6,
  parameter int BANK_LEN_LOG2  = 3,
  parameter int INPUT_WIDTH    = 12,
  parameter int TAP_WIDTH      = 16,
  parameter int INTERNAL_WIDTH = 35,
  parameter int NORM_SHIFT     = 13,
  parameter int OUTPUT_WIDTH   = 14
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_2mhz_pos_en,
  input  logic signed [INPUT_WIDTH-1:0]    din,
  input  logic        [M_LOG2:0]           tap_addr,
  input  logic signed [TAP_WIDTH-1:0]      tap0,
  input  logic signed [TAP_WIDTH-1:0]      tap1,
  input  logic signed [TAP_WIDTH-1:0]      tap2,
  input  logic signed [TAP_WIDTH-1:0]      tap3,
  input  logic signed [TAP_WIDTH-1:0]      tap4,
  input  logic signed [TAP_WIDTH-1:0]      tap5,
  input  logic signed [TAP_WIDTH-1:0]      tap6,
  input  logic signed [TAP_WIDTH-1:0]      tap7,
  input  logic signed [TAP_WIDTH-1:0]      tap8,
  input  logic signed [TAP_WIDTH-1:0]      tap9,
  input  logic signed [TAP_WIDTH-1:0]      tap10,
  input  logic signed [TAP_WIDTH-1:0]      tap11,
  input  logic signed [TAP_WIDTH-1:0]      tap12,
  input  logic signed [TAP_WIDTH-1:0]      tap13,
  input  logic signed [TAP_WIDTH-1:0]      tap14,
  input  logic signed [TAP_WIDTH-1:0]      tap15,
  input  logic signed [TAP_WIDTH-1:0]      tap16,
  input  logic signed [TAP_WIDTH-1:0]      tap17,
  input  logic signed [TAP_WIDTH-1:0]      tap18,
  input  logic signed [TAP_WIDTH-1:0]      tap19,
  output logic signed [OUTPUT_WIDTH-1:0]   dout,
  output logic                             dvalid
);

  localparam int NumTapPorts = 20;
  localparam int ProdWidth   = INPUT_WIDTH + TAP_WIDTH;
  localparam int AddrWidth   = M_LOG2 + 1;
  // BANK_LEN frames to fill the delay lines plus one frame of output latency.
  localparam int FillStrobes = BANK_LEN + 1;
  localparam int CntWidth    = $clog2(FillStrobes + 1);

  localparam logic [AddrWidth-1:0] BankLenAddr = AddrWidth'(BANK_LEN);
  localparam logic [CntWidth-1:0]  CntFull     = CntWidth'(FillStrobes);
  localparam logic [CntWidth-1:0]  CntOne      = CntWidth'(1);
  localparam logic signed [INTERNAL_WIDTH-1:0] OutMax =
      INTERNAL_WIDTH'(2 ** (OUTPUT_WIDTH - 1) - 1);
  localparam logic signed [INTERNAL_WIDTH-1:0] OutMin = ~OutMax;

  logic strobe;
  assign strobe = clk_2mhz_pos_en;

  // Tap ports gathered into an array indexed by bank number.
  logic signed [TAP_WIDTH-1:0] taps [NumTapPorts];
  assign taps[0]  = tap0;
  assign taps[1]  = tap1;
  assign taps[2]  = tap2;
  assign taps[3]  = tap3;
  assign taps[4]  = tap4;
  assign taps[5]  = tap5;
  assign taps[6]  = tap6;
  assign taps[7]  = tap7;
  assign taps[8]  = tap8;
  assign taps[9]  = tap9;
  assign taps[10] = tap10;
  assign taps[11] = tap11;
  assign taps[12] = tap12;
  assign taps[13] = tap13;
  assign taps[14] = tap14;
  assign taps[15] = tap15;
  assign taps[16] = tap16;
  assign taps[17] = tap17;
  assign taps[18] = tap18;
  assign taps[19] = tap19;

  logic signed [INPUT_WIDTH-1:0]    staging_q [M-1];
  logic signed [INPUT_WIDTH-1:0]    bank_q    [M][BANK_LEN];
  logic signed [INTERNAL_WIDTH-1:0] acc_q     [M];
  logic signed [INTERNAL_WIDTH-1:0] pending_q;
  logic        [CntWidth-1:0]       cnt_q;

  logic [BANK_LEN_LOG2-1:0]         bank_sel;
  logic                             mac_en;
  logic                             sum_en;
  logic signed [INPUT_WIDTH-1:0]    mac_smp   [M];
  logic signed [ProdWidth-1:0]      prod      [M];
  logic signed [INTERNAL_WIDTH-1:0] bank_sum;
  logic signed [INTERNAL_WIDTH-1:0] shifted;
  logic signed [OUTPUT_WIDTH-1:0]   sat_val;

  assign bank_sel = tap_addr[BANK_LEN_LOG2-1:0];
  assign mac_en   = (tap_addr < BankLenAddr);
  // The reduction runs once, on the clock after the last MAC; a strobe wins and skips it.
  assign sum_en   = (tap_addr == BankLenAddr) && !strobe;

  // Pick delay-line entry tap_addr from every bank and multiply by that bank's tap.
  always_comb begin
    for (int k = 0; k < M; k++) begin
      mac_smp[k] = '0;
      for (int j = 0; j < BANK_LEN; j++) begin
        if ((M * j + k < N_TAPS) && (bank_sel == BANK_LEN_LOG2'(j))) begin
          mac_smp[k] = bank_q[k][j];
        end
      end
      prod[k] = ProdWidth'(mac_smp[k]) * ProdWidth'(taps[k]);
    end
  end

  // Reduce all bank accumulators to one frame result.
  always_comb begin
    bank_sum = '0;
    for (int k = 0; k < M; k++) begin
      bank_sum = bank_sum + acc_q[k];
    end
  end

  // Normalise by arithmetic shift (floor) and clamp to the output range.
  always_comb begin
    shifted = pending_q >>> NORM_SHIFT;
    if (shifted > OutMax) begin
      sat_val = OUTPUT_WIDTH'(OutMax);
    end else if (shifted < OutMin) begin
      sat_val = OUTPUT_WIDTH'(OutMin);
    end else begin
      sat_val = OUTPUT_WIDTH'(shifted);
    end
  end

  // Staging line: the most recent M-1 input samples, shifted every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M - 1; i++) begin
        staging_q[i] <= '0;
      end
    end else begin
      staging_q[0] <= din;
      for (int i = 1; i < M - 1; i++) begin
        staging_q[i] <= staging_q[i-1];
      end
    end
  end

  // Bank delay lines advance one position per frame; bank k takes x[n-k].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < M; k++) begin
        for (int j = 0; j < BANK_LEN; j++) begin
          bank_q[k][j] <= '0;
        end
      end
    end else if (strobe) begin
      bank_q[0][0] <= din;
      for (int k = 1; k < M; k++) begin
        bank_q[k][0] <= staging_q[k-1];
      end
      for (int k = 0; k < M; k++) begin
        for (int j = 1; j < BANK_LEN; j++) begin
          bank_q[k][j] <= bank_q[k][j-1];
        end
      end
    end
  end

  // Per-bank accumulators: cleared at frame start, accumulate during the tap window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < M; k++) begin
        acc_q[k] <= '0;
      end
    end else if (strobe) begin
      for (int k = 0; k < M; k++) begin
        acc_q[k] <= '0;
      end
    end else if (mac_en) begin
      for (int k = 0; k < M; k++) begin
        acc_q[k] <= acc_q[k] + INTERNAL_WIDTH'(prod[k]);
      end
    end
  end

  // Pending result holds the last completed frame sum until the next strobe takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else if (sum_en) begin
      pending_q <= bank_sum;
    end
  end

  // Output register and fill counter, both advanced by the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      dvalid <= 1'b0;
      cnt_q  <= '0;
    end else if (strobe) begin
      dout <= sat_val;
      if (cnt_q != CntFull) begin
        cnt_q <= cnt_q + CntOne;
      end
      if (cnt_q == CntFull - CntOne) begin
        dvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_poly.sv
// Bench for fir_poly: a direct-convolution model over the sample history is checked against
// two DUT instances (default input width, and a 15-bit input copy so the 8192 impulse fits)
// every clock, alongside hand-computed literal expectations for key scenarios.
module tb_fir_poly;

  localparam int M  = 20;
  localparam int BL = 6;
  localparam int NT = 120;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                strobe = 1'b0;
  logic signed [14:0]  din_w = '0;
  logic signed [11:0]  din_n;
  logic [5:0]          tap_addr = '0;
  logic signed [15:0]  tap [M];
  logic signed [13:0]  dout_n, dout_w;
  logic                dvalid_n, dvalid_w;

  int h [NT];
  int vectors = 0;
  int miscompares = 0;
  int ph = 0;
  int unsigned junk;

  assign din_n = din_w[11:0];

  always #5 clk = ~clk;

  fir_poly u_dut (
    .clk(clk), .rst_n(rst_n), .clk_2mhz_pos_en(strobe), .din(din_n), .tap_addr(tap_addr),
    .tap0(tap[0]), .tap1(tap[1]), .tap2(tap[2]), .tap3(tap[3]), .tap4(tap[4]),
    .tap5(tap[5]), .tap6(tap[6]), .tap7(tap[7]), .tap8(tap[8]), .tap9(tap[9]),
    .tap10(tap[10]), .tap11(tap[11]), .tap12(tap[12]), .tap13(tap[13]), .tap14(tap[14]),
    .tap15(tap[15]), .tap16(tap[16]), .tap17(tap[17]), .tap18(tap[18]), .tap19(tap[19]),
    .dout(dout_n), .dvalid(dvalid_n)
  );

  fir_poly #(.INPUT_WIDTH(15)) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .clk_2mhz_pos_en(strobe), .din(din_w), .tap_addr(tap_addr),
    .tap0(tap[0]), .tap1(tap[1]), .tap2(tap[2]), .tap3(tap[3]), .tap4(tap[4]),
    .tap5(tap[5]), .tap6(tap[6]), .tap7(tap[7]), .tap8(tap[8]), .tap9(tap[9]),
    .tap10(tap[10]), .tap11(tap[11]), .tap12(tap[12]), .tap13(tap[13]), .tap14(tap[14]),
    .tap15(tap[15]), .tap16(tap[16]), .tap17(tap[17]), .tap18(tap[18]), .tap19(tap[19]),
    .dout(dout_w), .dvalid(dvalid_w)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int smp_n[$];
  int smp_w[$];
  int nstrobe = 0;
  longint y_n = 0, y_w = 0;
  logic signed [13:0] e_dout_n = '0, e_dout_w = '0;
  logic e_dvalid = 1'b0;

  // y = sum h[M*j+k] * x[n-k-M*j] over samples seen since reset; frames before reset are zero.
  function automatic longint frame_sum(input bit wide);
    longint acc;
    int t, idx, x;
    acc = 0;
    t = (wide ? smp_w.size() : smp_n.size()) - 1;
    for (int j = 0; j < BL; j++) begin
      if (j < nstrobe) begin
        for (int k = 0; k < M; k++) begin
          idx = t - k - M * j;
          if (idx >= 0) begin
            x = wide ? smp_w[idx] : smp_n[idx];
            acc += longint'(h[M * j + k]) * longint'(x);
          end
        end
      end
    end
    return acc;
  endfunction

  function automatic logic signed [13:0] sat_out(input longint y);
    longint s;
    s = y >>> 13;
    if (s > 8191) return 14'sd8191;
    if (s < -8192) return -14'sd8192;
    return 14'(s);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      smp_n.delete();
      smp_w.delete();
      nstrobe = 0;
      y_n = 0;
      y_w = 0;
      e_dout_n = '0;
      e_dout_w = '0;
      e_dvalid = 1'b0;
    end else begin
      smp_n.push_back(int'(din_n));
      smp_w.push_back(int'(din_w));
      if (strobe) begin
        e_dout_n = sat_out(y_n);
        e_dout_w = sat_out(y_w);
        nstrobe++;
        y_n = frame_sum(1'b0);
        y_w = frame_sum(1'b1);
        e_dvalid = (nstrobe >= BL + 1);
      end
    end
    #1;
    check("model_dout", dout_n, e_dout_n);
    check("model_dvalid", dvalid_n, e_dvalid);
    check("model_dout_wide", dout_w, e_dout_w);
    check("model_dvalid_wide", dvalid_w, e_dvalid);
  end

  // ---------------- stimulus ----------------
  // Drive one clock: strobe on the last phase, tap_addr = clocks since the strobe.
  task automatic step(input logic signed [14:0] d);
    din_w    = d;
    strobe   = (ph == M - 1);
    tap_addr = 6'(ph);
    junk     = $urandom;
    for (int k = 0; k < M; k++) begin
      if (ph < BL) tap[k] = 16'(h[M * ph + k]);
      else         tap[k] = 16'(junk + 32'(k) * 977);
    end
    @(posedge clk);
    #1;
    ph = (ph == M - 1) ? 0 : ph + 1;
  endtask

  task automatic run_frame(input logic signed [14:0] d, input int imp_pos,
                           input logic signed [14:0] imp);
    for (int p = 0; p < M; p++) step((p == imp_pos) ? imp : d);
  endtask

  // Reset with random din/strobe/tap_addr; taps loaded while the DUT is held.
  task automatic do_reset(input int mode);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NT; i++) begin
      case (mode)
        0:       h[i] = i + 1;
        1:       h[i] = 256;
        default: h[i] = 32767;
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      din_w    = 15'($urandom);
      strobe   = 1'($urandom);
      tap_addr = 6'($urandom);
      @(posedge clk);
      #1;
      check("reset_dout", dout_n, 0);
      check("reset_dvalid", dvalid_n, 0);
    end
    rst_n = 1'b1;
    ph = 0;
  endtask

  int imp1 [7] = '{1, 21, 41, 61, 81, 101, 0};
  int imp2 [6] = '{6, 26, 46, 66, 86, 106};

  initial begin
    for (int k = 0; k < M; k++) tap[k] = '0;

    // Impulse responses on the wide instance.
    do_reset(0);
    for (int f = 0; f < 7; f++) run_frame(15'sd0, -1, 15'sd0);
    run_frame(15'sd0, M - 1, 15'sd8192);
    for (int f = 0; f < 7; f++) begin
      run_frame(15'sd0, -1, 15'sd0);
      check("impulse_on_strobe", dout_w, imp1[f]);
    end
    run_frame(15'sd0, M - 6, 15'sd8192);
    for (int f = 0; f < 6; f++) begin
      run_frame(15'sd0, -1, 15'sd0);
      check("impulse_5_early", dout_w, imp2[f]);
    end

    // DC fill and dvalid timing.
    do_reset(1);
    for (int f = 1; f <= 9; f++) begin
      run_frame(15'sd2047, -1, 15'sd0);
      check("dc_dvalid", dvalid_n, (f >= 7) ? 1 : 0);
      if (f >= 7) check("dc_value", dout_n, 7676);
    end

    // Mid-run reset inside the MAC window, then recovery.
    for (int p = 0; p < M; p++) begin
      step(15'sd2047);
      if (p == 2) begin
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dout", dout_n, 0);
        check("midrst_dvalid", dvalid_n, 0);
      end
      if (p == 4) #2 rst_n = 1'b1;
    end
    check("midrst_strobe1_dvalid", dvalid_n, 0);
    for (int s = 2; s <= 8; s++) begin
      run_frame(15'sd2047, -1, 15'sd0);
      check("recover_dvalid", dvalid_n, (s >= 7) ? 1 : 0);
      if (s == 8) check("recover_value", dout_n, 7676);
    end

    // Saturation, negative then positive.
    do_reset(2);
    for (int f = 0; f < 8; f++) run_frame(-15'sd2048, -1, 15'sd0);
    check("sat_negative", dout_n, -8192);
    do_reset(2);
    for (int f = 0; f < 8; f++) run_frame(15'sd2047, -1, 15'sd0);
    check("sat_positive", dout_n, 8191);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_poly.md
FIR_POLY -- requirements
Module: fir_poly

Interface
REQ-001 SHALL have parameter N_TAPS, default 120: total prototype filter taps.
REQ-002 SHALL have parameter M, default 20: decimation factor and number of polyphase banks; M_LOG2, default 5.
REQ-003 SHALL have parameter BANK_LEN, default 6 (N_TAPS/M): taps per bank; BANK_LEN_LOG2, default 3.
REQ-004 SHALL have parameter INPUT_WIDTH, default 12; TAP_WIDTH, default 16; INTERNAL_WIDTH, default 35; NORM_SHIFT, default 13; OUTPUT_WIDTH, default 14.
REQ-005 SHALL have port clk  in  1: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port clk_2mhz_pos_en  in  1: output-rate strobe, one clk cycle high per frame (nominally every M clocks).
REQ-008 SHALL have port din  in  INPUT_WIDTH signed: input sample, one per clk.
REQ-009 SHALL have port tap_addr  in  M_LOG2+1: external tap-ROM address; 0 on the cycle after the strobe, +1 per clk.
REQ-010 SHALL have ports tap0..tap19  in  TAP_WIDTH signed each: tapk = h[M*j+k], where j = tap_addr[BANK_LEN_LOG2-1:0], valid while tap_addr < BANK_LEN (combinational ROM read, same cycle).
REQ-011 SHALL have port dout  out  OUTPUT_WIDTH signed: decimated filter output.
REQ-012 SHALL have port dvalid  out  1: dout holds a result from a fully populated delay line.

Function
REQ-013 SHALL compute, per frame, y = sum over k=0..M-1, j=0..BANK_LEN-1 of h[M*j+k]*x[n-k-M*j], where x[n] is the din sampled on the strobe cycle.
REQ-014 SHALL keep a staging shift register of the last M-1 samples, shifted every clk.
REQ-015 SHALL hold per-bank delay lines b_k[0..BANK_LEN-1], shifted only on strobe edges: b_k[0] <= x[n-k] (din for k=0, staging otherwise), b_k[j] <= b_k[j-1].
REQ-016 SHALL, while tap_addr = 0..BANK_LEN-1, multiply b_k[tap_addr] by tapk for all M banks in parallel and accumulate; products are INPUT_WIDTH+TAP_WIDTH signed, sign-extended into INTERNAL_WIDTH accumulators; accumulators clear on strobe edges.
REQ-017 SHALL sum the M bank accumulators into a pending result, complete no later than tap_addr = BANK_LEN+3.
REQ-018 SHALL form the output as pending >>> NORM_SHIFT (arithmetic, truncation toward minus infinity, no rounding), saturated to the OUTPUT_WIDTH signed range [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
REQ-019 SHALL register dout on the clock edge where the strobe is high and hold it between strobes; latency = one frame (frame-n result appears after the frame-n+1 strobe edge).
REQ-020 SHALL count strobes from reset (saturating) and set dvalid at the 7th strobe edge (BANK_LEN fill frames + 1 latency frame); it stays high until reset.
REQ-021 SHALL, if a strobe arrives before the MAC/sum completes, transfer the pending value as-is and restart the frame; no error flag.
REQ-022 SHALL ignore tap inputs whenever tap_addr >= BANK_LEN.

Reset
REQ-023 SHALL, while rst_n low, force dout=0, dvalid=0, and clear staging, bank, accumulator, pending and strobe-count registers, asynchronously and regardless of strobe.
REQ-024 SHALL, after rst_n deasserts mid-frame, start at the first strobe with an empty delay line (dvalid again at the 7th strobe).

Verification
REQ-025 Reset: rst_n=0 with random din and strobe -> dout=0, dvalid=0 throughout.
REQ-026 Impulse: h[i]=i+1; din=8192 on one strobe cycle, 0 elsewhere -> successive dout 1,21,41,61,81,101, then 0; impulse 5 clks before a strobe -> 6,26,46,66,86,106.
REQ-027 DC: all taps 256, din=2047 constant -> dout=7676 once filled; dvalid low for the first 6 strobes, high from the 7th.
REQ-028 Saturation: all taps 32767, din=-2048 -> dout=-8192; taps 32767, din=2047 -> dout=8191.
REQ-029 Mid-run reset: rst_n pulsed low for 2 clks during the MAC window -> dout=0 and dvalid=0 immediately; DC scenario values recovered 7 strobes later.
